// File: rtl/vector_conv_sequencer.sv
// Control sequencer for the vector pixel/kernel datapath: walks a ROWS x COLS
// grid and, for each pixel word, steps through pixel loads, multiplier loads
// and the WOM store. All outputs are registered from the current state.
module vector_conv_sequencer #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter logic [31:0] WOM_BASE = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic        wr_pxl,
    output logic        wr_pos,
    output logic        wr_mul_reg,
    output logic        wr_mul_pos_out,
    output logic        alu_func,
    output logic        wr_wom,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] n,
    output logic [31:0] wom_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_LDP0, S_LDP1, S_MUL0, S_MUL1, S_WR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] row_q, row_d, col_q, col_d, elem_q, elem_d;
    logic        last_elem;

    logic        busy_q, busy_d, done_q, done_d;
    logic        wr_pxl_q, wr_pxl_d, wr_pos_q, wr_pos_d;
    logic        wr_mul_reg_q, wr_mul_reg_d, wr_mul_pos_q, wr_mul_pos_d;
    logic        alu_func_q, alu_func_d, wr_wom_q, wr_wom_d;
    logic [31:0] i_q, i_d, j_q, j_d, n_q, n_d, wom_addr_q, wom_addr_d;

    assign last_elem = (row_q == 32'(ROWS - 1)) && (col_q == 32'(COLS - 1));

    // Next state and loop indices; stall freezes everything except an IDLE start.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        elem_d  = elem_q;
        if (!stall || state_q == S_IDLE) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_d   = '0;
                        col_d   = '0;
                        elem_d  = '0;
                        state_d = S_LDP0;
                    end
                end
                S_LDP0: state_d = S_LDP1;
                S_LDP1: state_d = S_MUL0;
                S_MUL0: state_d = S_MUL1;
                S_MUL1: state_d = S_WR;
                S_WR: begin
                    if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        elem_d = elem_q + 32'd1;
                        if (col_q == 32'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 32'd1;
                        end else begin
                            col_d = col_q + 32'd1;
                        end
                        state_d = S_LDP0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode of the current state; stall masks strobes, indices hold in IDLE.
    always_comb begin
        busy_d       = (state_q != S_IDLE);
        wr_pos_d     = (state_q == S_LDP1);
        wr_mul_pos_d = (state_q == S_MUL1);
        alu_func_d   = (state_q == S_MUL0) || (state_q == S_MUL1);
        wr_pxl_d     = ((state_q == S_LDP0) || (state_q == S_LDP1)) && !stall;
        wr_mul_reg_d = alu_func_d && !stall;
        wr_wom_d     = (state_q == S_WR) && !stall;
        done_d       = (state_q == S_DONE) && !stall;
        i_d          = i_q;
        j_d          = j_q;
        n_d          = n_q;
        wom_addr_d   = wom_addr_q;
        if (state_q != S_IDLE) begin
            i_d        = row_q;
            j_d        = col_q;
            n_d        = elem_q;
            wom_addr_d = WOM_BASE + elem_q;
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            elem_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_pxl_q     <= 1'b0;
            wr_pos_q     <= 1'b0;
            wr_mul_reg_q <= 1'b0;
            wr_mul_pos_q <= 1'b0;
            alu_func_q   <= 1'b0;
            wr_wom_q     <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            n_q          <= '0;
            wom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            elem_q       <= elem_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wr_pxl_q     <= wr_pxl_d;
            wr_pos_q     <= wr_pos_d;
            wr_mul_reg_q <= wr_mul_reg_d;
            wr_mul_pos_q <= wr_mul_pos_d;
            alu_func_q   <= alu_func_d;
            wr_wom_q     <= wr_wom_d;
            i_q          <= i_d;
            j_q          <= j_d;
            n_q          <= n_d;
            wom_addr_q   <= wom_addr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign wr_pxl         = wr_pxl_q;
    assign wr_pos         = wr_pos_q;
    assign wr_mul_reg     = wr_mul_reg_q;
    assign wr_mul_pos_out = wr_mul_pos_q;
    assign alu_func       = alu_func_q;
    assign wr_wom         = wr_wom_q;
    assign i              = i_q;
    assign j              = j_q;
    assign n              = n_q;
    assign wom_addr       = wom_addr_q;

endmodule

// File: tb/tb_vector_conv_sequencer.sv
// Directed bench for vector_conv_sequencer: a 2x3 grid instance (WOM_BASE=16)
// and a 1x1 instance (WOM_BASE=0xA5), with a WOM-store scoreboard on the first.
module tb_vector_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, stall_a, start_b, stall_b;

    logic        a_busy, a_done, a_wr_pxl, a_wr_pos, a_wr_mul_reg, a_wr_mul_pos, a_alu, a_wr_wom;
    logic [31:0] a_i, a_j, a_n, a_wom_addr;
    logic        b_busy, b_done, b_wr_pxl, b_wr_pos, b_wr_mul_reg, b_wr_mul_pos, b_alu, b_wr_wom;
    logic [31:0] b_i, b_j, b_n, b_wom_addr;

    typedef struct {
        logic [31:0] i;
        logic [31:0] j;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pxl_cnt = 0;
    int   wom_cnt = 0;

    always #5 clk = ~clk;

    vector_conv_sequencer #(.ROWS(2), .COLS(3), .WOM_BASE(32'd16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
        .busy(a_busy), .done(a_done), .wr_pxl(a_wr_pxl), .wr_pos(a_wr_pos),
        .wr_mul_reg(a_wr_mul_reg), .wr_mul_pos_out(a_wr_mul_pos), .alu_func(a_alu),
        .wr_wom(a_wr_wom), .i(a_i), .j(a_j), .n(a_n), .wom_addr(a_wom_addr)
    );

    vector_conv_sequencer #(.ROWS(1), .COLS(1), .WOM_BASE(32'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
        .busy(b_busy), .done(b_done), .wr_pxl(b_wr_pxl), .wr_pos(b_wr_pos),
        .wr_mul_reg(b_wr_mul_reg), .wr_mul_pos_out(b_wr_mul_pos), .alu_func(b_alu),
        .wr_wom(b_wr_wom), .i(b_i), .j(b_j), .n(b_n), .wom_addr(b_wom_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] a_ctl();
        return {a_wr_pxl, a_wr_pos, a_wr_mul_reg, a_wr_mul_pos, a_alu, a_wr_wom, a_done, a_busy};
    endfunction

    function automatic logic [7:0] b_ctl();
        return {b_wr_pxl, b_wr_pos, b_wr_mul_reg, b_wr_mul_pos, b_alu, b_wr_wom, b_done, b_busy};
    endfunction

    task automatic push_pass();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                sb.push_back('{i: 32'(r), j: 32'(c), addr: 32'(16 + r * 3 + c)});
    endtask

    // Per-cycle observation: strobe exclusivity on both instances, scoreboard on A.
    task automatic monitor();
        exp_t e;
        check("onehot_a", 64'($onehot0({a_wr_pxl, a_wr_mul_reg, a_wr_wom})), 64'(1));
        check("onehot_b", 64'($onehot0({b_wr_pxl, b_wr_mul_reg, b_wr_wom})), 64'(1));
        if (a_wr_pxl) pxl_cnt++;
        if (a_wr_wom) begin
            wom_cnt++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_i", 64'(a_i), 64'(e.i));
                check("sb_j", 64'(a_j), 64'(e.j));
                check("sb_addr", 64'(a_wom_addr), 64'(e.addr));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    initial begin
        int t;
        bit stalled;
        bit found;
        logic [7:0] b_exp [7];

        rst = 1'b0; start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
        #2;
        check("por_ctl_a", 64'(a_ctl()), 64'(0));
        check("por_idx_a", {a_n, a_wom_addr}, 64'(0));
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        check("idle_ctl_a", 64'(a_ctl()), 64'(0));
        check("idle_ctl_b", 64'(b_ctl()), 64'(0));

        // Nominal 2x3 pass; start pulses mid-pass and in DONE are ignored.
        push_pass();
        wom_cnt = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t = 0;
        found = 1'b0;
        while (t < 60 && !found) begin
            start_a = (t == 9) || (t == 30);
            tick();
            t++;
            if (t == 1) check("first_ldp0", 64'(a_ctl()), 64'(8'b1000_0001));
            found = a_done;
        end
        check("t2_done_cycle", 64'(t), 64'(31));
        check("t2_wom_cnt", 64'(wom_cnt), 64'(6));
        check("t2_sb_empty", 64'(sb.size()), 64'(0));

        // Start held one more cycle after the done pulse launches the next pass.
        push_pass();
        pxl_cnt = 0;
        wom_cnt = 0;
        tick();
        start_a = 1'b0;
        check("after_done_busy", 64'(a_busy), 64'(0));
        check("after_done_n_hold", 64'(a_n), 64'(5));
        tick();
        t = 1;
        check("restart_busy", 64'(a_busy), 64'(1));
        check("restart_n", 64'(a_n), 64'(0));
        check("restart_ldp0", 64'(a_ctl()), 64'(8'b1000_0001));

        // Three-cycle stall while element n=2 sits in LDP1.
        stalled = 1'b0;
        found = 1'b0;
        while (t < 80 && !found) begin
            tick();
            t++;
            if (!stalled && a_wr_pxl && !a_wr_pos && a_n == 32'd2) begin
                stall_a = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    t++;
                    check("stall_ctl", 64'(a_ctl()), 64'(8'b0100_0001));
                    check("stall_n", 64'(a_n), 64'(2));
                end
                stall_a = 1'b0;
                tick();
                t++;
                check("ldp1_resume", 64'(a_ctl()), 64'(8'b1100_0001));
                stalled = 1'b1;
            end
            found = a_done;
        end
        check("t3_stalled", 64'(stalled), 64'(1));
        check("t3_done_cycle", 64'(t), 64'(34));
        check("t3_pxl_cnt", 64'(pxl_cnt), 64'(12));
        check("t3_wom_cnt", 64'(wom_cnt), 64'(6));
        check("t3_sb_empty", 64'(sb.size()), 64'(0));
        tick();

        // Asynchronous reset in the middle of MUL0.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            found = a_wr_mul_reg && !a_wr_mul_pos;
        end
        check("t1_reached_mul0", 64'(found), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("t1_ctl_zero", 64'(a_ctl()), 64'(0));
        check("t1_ij_zero", {a_i, a_j}, 64'(0));
        check("t1_n_addr_zero", {a_n, a_wom_addr}, 64'(0));
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        check("t1_stay_idle", 64'(a_ctl()), 64'(0));

        // Single-element 1x1 pass on the second instance.
        b_exp = '{8'b1000_0001, 8'b1100_0001, 8'b0010_1001, 8'b0011_1001,
                  8'b0000_0101, 8'b0000_0011, 8'b0000_0000};
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t5_ctl_%0d", k + 1), 64'(b_ctl()), 64'(b_exp[k]));
            if (k == 4) begin
                check("t5_addr", 64'(b_wom_addr), 64'(32'hA5));
                check("t5_ijn", {b_i, b_j | b_n}, 64'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
